// File: rtl/zebra_pkg.sv
// Shared types for the zebra crossing pipeline: pixel codes, writer FSM states and a
// majority-vote helper.
package zebra_pkg;

  typedef logic [1:0] pix_code_t;

  localparam pix_code_t PIX_BLACK   = 2'b00;
  localparam pix_code_t PIX_WHITE   = 2'b01;
  localparam pix_code_t PIX_VISITED = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StWaitDet
  } writer_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/row_majority3.sv
// 3-tap horizontal majority filter over binarised pixels. Emits each pixel once its right
// neighbour arrives; the last pixel of a row is flushed on the cycle after eol.
module row_majority3
  import zebra_pkg::*;
#(
  parameter int unsigned AddrW = 19
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic             in_bit_i,
  input  logic             in_first_i,
  input  logic             in_last_i,
  input  logic [AddrW-1:0] in_addr_i,
  output logic             out_valid_o,
  output pix_code_t        out_code_o,
  output logic [AddrW-1:0] out_addr_o
);

  logic             prev_q, prev_d;
  logic             cur_q, cur_d;
  logic             flush_q, flush_d;
  logic [AddrW-1:0] cur_addr_q, cur_addr_d;
  logic             out_valid_q, out_valid_d;
  pix_code_t        out_code_q, out_code_d;
  logic [AddrW-1:0] out_addr_q, out_addr_d;

  always_comb begin
    prev_d      = prev_q;
    cur_d       = cur_q;
    flush_d     = 1'b0;
    cur_addr_d  = cur_addr_q;
    out_valid_d = 1'b0;
    out_code_d  = out_code_q;
    out_addr_d  = out_addr_q;

    // Right edge replicates the held pixel.
    if (flush_q) begin
      out_valid_d = 1'b1;
      out_code_d  = maj3(prev_q, cur_q, cur_q) ? PIX_WHITE : PIX_BLACK;
      out_addr_d  = cur_addr_q;
    end

    if (in_valid_i) begin
      if (in_first_i) begin
        // Left edge replicates the first pixel; nothing to emit yet.
        prev_d     = in_bit_i;
        cur_d      = in_bit_i;
        cur_addr_d = in_addr_i;
      end else begin
        out_valid_d = 1'b1;
        out_code_d  = maj3(prev_q, cur_q, in_bit_i) ? PIX_WHITE : PIX_BLACK;
        out_addr_d  = cur_addr_q;
        prev_d      = cur_q;
        cur_d       = in_bit_i;
        cur_addr_d  = in_addr_i;
        flush_d     = in_last_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q      <= 1'b0;
      cur_q       <= 1'b0;
      flush_q     <= 1'b0;
      cur_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_code_q  <= PIX_BLACK;
      out_addr_q  <= '0;
    end else begin
      prev_q      <= prev_d;
      cur_q       <= cur_d;
      flush_q     <= flush_d;
      cur_addr_q  <= cur_addr_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_addr_q  <= out_addr_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_code_o  = out_code_q;
  assign out_addr_o  = out_addr_q;

endmodule

// File: rtl/binary_frame_writer.sv
// Thresholds a streamed grayscale frame into the shared image BRAM and hands it to the
// detector. Define BINARIZE_MAJORITY_EN to add a 3-tap horizontal majority filter.
module binary_frame_writer
  import zebra_pkg::*;
#(
  parameter int unsigned IMG_WIDTH         = 640,
  parameter int unsigned IMG_HEIGHT        = 480,
  parameter logic [7:0]  DEFAULT_THRESHOLD = 8'd128,
  localparam int unsigned AddrW            = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  input  logic [7:0]       pix_data,
  input  logic             pix_sof,
  input  logic             pix_eol,
  input  logic             thr_wr,
  input  logic [7:0]       thr_data,
  output logic [AddrW-1:0] bram_wr_addr,
  output logic [1:0]       bram_wr_data,
  output logic             bram_wr_en,
  output logic             valid_to_read,
  input  logic             detection_valid,
  output logic             frame_err,
  output logic [15:0]      frames_dropped
);

  localparam int unsigned ColW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [ColW-1:0]  LastCol  = ColW'(IMG_WIDTH - 1);
  localparam logic [AddrW-1:0] LastAddr = AddrW'(IMG_WIDTH * IMG_HEIGHT - 1);

  writer_state_e    state_q, state_d;
  logic [ColW-1:0]  col_q, col_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [7:0]       thr_q, thr_d;
  logic [7:0]       thr_act_q, thr_act_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [15:0]      dropped_q, dropped_d;

  logic             sof_accept;
  logic             px_we;
  logic [AddrW-1:0] px_addr;
  logic [7:0]       thr_use;
  logic             px_bit;

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    addr_d     = addr_q;
    thr_d      = thr_wr ? thr_data : thr_q;
    thr_act_d  = thr_act_q;
    err_d      = 1'b0;
    dropped_d  = dropped_q;
    sof_accept = 1'b0;
    px_we      = 1'b0;
    px_addr    = addr_q;

    case (state_q)
      StIdle: begin
        if (pix_valid && pix_sof) sof_accept = 1'b1;
      end
      StWrite: begin
        if (pix_valid) begin
          if (pix_sof) begin
            sof_accept = 1'b1;
            err_d      = 1'b1;
          end else if (pix_eol != (col_q == LastCol)) begin
            // Misplaced or missing eol: abandon the partial frame.
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            px_we  = 1'b1;
            addr_d = addr_q + AddrW'(1);
            if (pix_eol) begin
              col_d = '0;
              if (addr_q == LastAddr) state_d = StWaitDet;
            end else begin
              col_d = col_q + ColW'(1);
            end
          end
        end
      end
      StWaitDet: begin
        if (pix_valid && pix_sof && (dropped_q != 16'hFFFF)) dropped_d = dropped_q + 16'd1;
        if (detection_valid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (sof_accept) begin
      px_we     = 1'b1;
      px_addr   = '0;
      addr_d    = AddrW'(1);
      col_d     = ColW'(1);
      state_d   = StWrite;
      thr_act_d = thr_q;
    end

    // The shadow threshold switches only at an accepted sof, including for that pixel.
    thr_use = sof_accept ? thr_q : thr_act_q;
    px_bit  = (pix_data >= thr_use);

    valid_d = valid_q;
    if (state_q == StWaitDet) begin
      if (detection_valid) begin
        valid_d = 1'b0;
      end else if (bram_wr_en && (bram_wr_addr == LastAddr)) begin
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      col_q     <= '0;
      addr_q    <= '0;
      thr_q     <= DEFAULT_THRESHOLD;
      thr_act_q <= DEFAULT_THRESHOLD;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      dropped_q <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      addr_q    <= addr_d;
      thr_q     <= thr_d;
      thr_act_q <= thr_act_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      dropped_q <= dropped_d;
    end
  end

  assign valid_to_read  = valid_q;
  assign frame_err      = err_q;
  assign frames_dropped = dropped_q;

`ifdef BINARIZE_MAJORITY_EN
  logic      px_first;
  pix_code_t flt_code;

  assign px_first = sof_accept | (col_q == '0);

  row_majority3 #(
    .AddrW(AddrW)
  ) u_row_majority3 (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (px_we),
    .in_bit_i   (px_bit),
    .in_first_i (px_first),
    .in_last_i  (pix_eol),
    .in_addr_i  (px_addr),
    .out_valid_o(bram_wr_en),
    .out_code_o (flt_code),
    .out_addr_o (bram_wr_addr)
  );

  assign bram_wr_data = flt_code;
`else
  logic             wr_en_q, wr_en_d;
  logic [AddrW-1:0] wr_addr_q, wr_addr_d;
  pix_code_t        wr_data_q, wr_data_d;

  always_comb begin
    wr_en_d   = px_we;
    wr_addr_d = px_we ? px_addr : wr_addr_q;
    wr_data_d = wr_data_q;
    if (px_we) wr_data_d = px_bit ? PIX_WHITE : PIX_BLACK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= PIX_BLACK;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bram_wr_en   = wr_en_q;
  assign bram_wr_addr = wr_addr_q;
  assign bram_wr_data = wr_data_q;
`endif

endmodule

// File: tb/tb_binary_frame_writer.sv
// Scoreboard bench for binary_frame_writer on an 8x4 frame; the reference model follows the
// frame/threshold/majority rules directly on pixel arrays.
module tb_binary_frame_writer;

  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;

`ifdef BINARIZE_MAJORITY_EN
  localparam bit Maj = 1'b1;
`else
  localparam bit Maj = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_sof;
  logic        pix_eol;
  logic        thr_wr;
  logic [7:0]  thr_data;
  logic [4:0]  bram_wr_addr;
  logic [1:0]  bram_wr_data;
  logic        bram_wr_en;
  logic        valid_to_read;
  logic        detection_valid;
  logic        frame_err;
  logic [15:0] frames_dropped;

  always #5 clk = ~clk;

  binary_frame_writer #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pix_valid      (pix_valid),
    .pix_data       (pix_data),
    .pix_sof        (pix_sof),
    .pix_eol        (pix_eol),
    .thr_wr         (thr_wr),
    .thr_data       (thr_data),
    .bram_wr_addr   (bram_wr_addr),
    .bram_wr_data   (bram_wr_data),
    .bram_wr_en     (bram_wr_en),
    .valid_to_read  (valid_to_read),
    .detection_valid(detection_valid),
    .frame_err      (frame_err),
    .frames_dropped (frames_dropped)
  );

  int checks = 0;
  int errors = 0;
  int err_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected writes, encoded addr*4 + code.
  int exp_q[$];

  // Reference model: 0 = idle, 1 = writing, 2 = frame held for detector.
  int m_mode, m_row, m_col, m_thr_reg, m_thr_act, m_dropped, m_err;
  int rb[$];
  logic [7:0] fb[N];

  function automatic int maj(input int a, input int b, input int c);
    return ((a + b + c) >= 2) ? 1 : 0;
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_row = 0; m_col = 0;
    m_thr_reg = 128; m_thr_act = 128; m_dropped = 0;
    rb.delete();
  endfunction

  function automatic void model_pixel(input int d, input bit sof, input bit eol);
    int b, a, c;
    if (m_mode == 2) begin
      if (sof && m_dropped < 65535) m_dropped++;
      return;
    end
    if (m_mode == 0 && !sof) return;
    if (sof) begin
      if (m_mode == 1) m_err++;
      m_thr_act = m_thr_reg;
      m_row = 0; m_col = 0; m_mode = 1;
    end else if (eol != (m_col == W - 1)) begin
      m_err++;
      m_mode = 0;
      return;
    end
    b = (d >= m_thr_act) ? 1 : 0;
    a = m_row * W + m_col;
    c = m_col;
    if (c == 0) rb.delete();
    rb.push_back(b);
    if (!Maj) begin
      exp_q.push_back(a * 4 + b);
    end else begin
      if (c > 0) exp_q.push_back((a - 1) * 4 + maj(rb[(c >= 2) ? c - 2 : 0], rb[c - 1], rb[c]));
      if (eol) exp_q.push_back(a * 4 + maj(rb[c - 1], rb[c], rb[c]));
    end
    if (eol) begin
      m_col = 0;
      m_row++;
      if (m_row == H) m_mode = 2;
    end else begin
      m_col++;
    end
  endfunction

  // Monitor: pops one expectation per observed write and checks valid_to_read timing.
  bit last_wr_prev = 1'b0;
  always @(negedge clk) begin
    bit last_wr_now;
    int e;
    if (bram_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0d, expected no write",
                 bram_wr_addr, bram_wr_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(bram_wr_addr), 32'(e / 4));
        check("wr_data", 32'(bram_wr_data), 32'(e % 4));
      end
    end
    if (last_wr_prev) check("vtr_rise_after_last_write", 32'(valid_to_read), 1);
    last_wr_now = (bram_wr_en === 1'b1) && (bram_wr_addr == 5'(N - 1));
    if (last_wr_now) check("vtr_low_at_last_write", 32'(valid_to_read), 0);
    last_wr_prev = last_wr_now;
    if (frame_err === 1'b1) err_seen++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] d, input bit sof, input bit eol, input bit det);
    model_pixel(d, sof, eol);
    if (det && m_mode == 2) m_mode = 0;
    pix_valid = 1'b1; pix_data = d; pix_sof = sof; pix_eol = eol; detection_valid = det;
    @(posedge clk);
    #1;
    pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0; detection_valid = 1'b0;
    if ($urandom_range(3) == 0) idle(1);
  endtask

  task automatic send_range(input int start, input int stop);
    for (int i = start; i < stop; i++) drive(fb[i], i == 0, (i % W) == W - 1, 1'b0);
  endtask

  task automatic fill_random(input int hi);
    for (int i = 0; i < N; i++) fb[i] = 8'($urandom_range(hi));
  endtask

  task automatic thr_write(input logic [7:0] v);
    thr_wr = 1'b1; thr_data = v;
    @(posedge clk);
    #1;
    thr_wr = 1'b0;
    m_thr_reg = v;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1);
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    idle(3);
  endtask

  task automatic pulse_det();
    check("vtr_before_det", 32'(valid_to_read), (m_mode == 2) ? 1 : 0);
    if (m_mode == 2) m_mode = 0;
    detection_valid = 1'b1;
    @(posedge clk);
    #1;
    detection_valid = 1'b0;
    check("vtr_after_det", 32'(valid_to_read), 0);
    idle(1);
  endtask

  initial begin
    rst = 1'b1; pix_valid = 1'b0; pix_data = '0; pix_sof = 1'b0; pix_eol = 1'b0;
    thr_wr = 1'b0; thr_data = '0; detection_valid = 1'b0;
    m_err = 0;
    model_reset();
    idle(3);
    rst = 1'b0;

    check("rst_vtr", 32'(valid_to_read), 0);
    check("rst_wr_en", 32'(bram_wr_en), 0);
    check("rst_wr_addr", 32'(bram_wr_addr), 0);
    check("rst_wr_data", 32'(bram_wr_data), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_dropped", 32'(frames_dropped), 0);

    // detection_valid outside WAIT_DET has no effect.
    pulse_det();

    // Ramp frame at the default threshold.
    for (int i = 0; i < N; i++) fb[i] = 8'(i * 8);
    send_range(0, N);
    drain();
    check("vtr_after_ramp", 32'(valid_to_read), (m_mode == 2) ? 1 : 0);

    // Two frames arrive while the detector still owns the BRAM.
    for (int f = 0; f < 2; f++) begin
      fill_random(255);
      send_range(0, N);
    end
    idle(2);
    check("dropped_two", 32'(frames_dropped), 32'(m_dropped));
    check("vtr_held", 32'(valid_to_read), 1);
    pulse_det();

    fill_random(255);
    send_range(0, N);
    drain();
    check("vtr_third_frame", 32'(valid_to_read), (m_mode == 2) ? 1 : 0);

    // sof together with detection_valid: dropped, rest of that frame ignored.
    fill_random(255);
    drive(fb[0], 1'b1, 1'b0, 1'b1);
    send_range(1, N);
    drain();
    check("dropped_with_det", 32'(frames_dropped), 32'(m_dropped));
    check("vtr_after_sof_det", 32'(valid_to_read), 0);

    // eol at col 5 of row 1.
    fill_random(255);
    send_range(0, 13);
    drive(fb[13], 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(8'hFF, 1'b0, 1'b0, 1'b0);
    drain();
    check("err_eol_count", 32'(err_seen), 32'(m_err));
    check("err_eol_vtr", 32'(valid_to_read), 0);

    // Missing eol at col 7 of row 0.
    fill_random(255);
    send_range(0, 7);
    drive(fb[7], 1'b0, 1'b0, 1'b0);
    drain();
    check("err_noeol_count", 32'(err_seen), 32'(m_err));

    // sof at address 13 restarts the frame.
    fill_random(255);
    send_range(0, 13);
    send_range(0, N);
    drain();
    check("err_sof_count", 32'(err_seen), 32'(m_err));
    check("vtr_after_restart", 32'(valid_to_read), (m_mode == 2) ? 1 : 0);
    pulse_det();

    // Threshold change mid-frame applies from the next frame.
    fill_random(200);
    fb[3] = 8'd50;
    send_range(0, 10);
    thr_write(8'd10);
    send_range(10, N);
    drain();
    pulse_det();
    fill_random(40);
    send_range(0, N);
    drain();
    pulse_det();

    // Isolated-pixel row pattern.
    thr_write(8'd128);
    fill_random(255);
    for (int i = 0; i < W; i++) fb[i] = ((8'b1011_0010 >> i) & 1) != 0 ? 8'd200 : 8'd20;
    send_range(0, N);
    drain();
    pulse_det();

    // Reset mid-frame after a threshold change and with a non-zero drop count.
    thr_write(8'd37);
    fill_random(255);
    send_range(0, 20);
    idle(3);
    drain();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    model_reset();
    check("mid_rst_dropped", 32'(frames_dropped), 0);
    check("mid_rst_vtr", 32'(valid_to_read), 0);
    check("mid_rst_wr_en", 32'(bram_wr_en), 0);
    check("mid_rst_wr_addr", 32'(bram_wr_addr), 0);
    fill_random(255);
    send_range(0, N);
    drain();
    pulse_det();

    // Random frames at random thresholds.
    for (int f = 0; f < 4; f++) begin
      thr_write(8'($urandom_range(255)));
      fill_random(255);
      send_range(0, N);
      drain();
      pulse_det();
    end

    check("final_err_count", 32'(err_seen), 32'(m_err));
    check("final_dropped", 32'(frames_dropped), 32'(m_dropped));
    check("final_queue_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule
